jtkicker_vout: RTL
==================

// Module: jtkicker_vout
// PURPOSE
//  Video output stage, directly downstream of jtkicker_video. Registers the colour-mixer RGB and blanking onto a fixed pixel pipeline.
//  Re-times HS/VS with user-programmable horizontal (pixel) and vertical (line) offsets, so the picture can be centred on the CRT.
//  Forces black outside the active area and produces a data-enable for scalers.
// PARAMETERS
//  PDLY   9   pixel-pipeline latency (pxl_cen ticks) of RGB, LHBL and LVBL.
//  VBASE  8   nominal line delay of VS; the effective delay is VBASE+voffset.
// PORTS
//  clk       in   1  48 MHz system clock
//  rst       in   1  asynchronous, active-high reset
//  pxl_cen   in   1  pixel clock enable; all pipelines advance only on it
//  hoffset   in   4  signed horizontal sync offset, -8..+7 pixels
//  voffset   in   4  signed vertical sync offset, -8..+7 lines
//  red       in   4  colour mixer red
//  green     in   4  colour mixer green
//  blue      in   4  colour mixer blue
//  LHBL_dly  in   1  horizontal blank, active low, aligned to RGB
//  LVBL_dly  in   1  vertical blank, active low, aligned to RGB
//  HS        in   1  horizontal sync from the timer, active high
//  VS        in   1  vertical sync from the timer, active high
//  vid_r     out  4  output red; 0 while blanked
//  vid_g     out  4  output green; 0 while blanked
//  vid_b     out  4  output blue; 0 while blanked
//  vid_hs    out  1  re-timed horizontal sync
//  vid_vs    out  1  re-timed vertical sync
//  vid_lhbl  out  1  delayed LHBL_dly
//  vid_lvbl  out  1  delayed LVBL_dly
//  vid_de    out  1  vid_lhbl & vid_lvbl
// BEHAVIOUR
//  Reset (async, rst=1):
//   - all outputs 0; all shift registers 0.
//   - active offsets hoff_a = voff_a = 0; line counter state cleared.
//   - After release, outputs stay 0 until valid data has propagated through the pipeline.
//  Pixel pipeline:
//   - PDLY-stage shift register on pxl_cen carries {red,green,blue,LHBL_dly,LVBL_dly}.
//   - vid_lhbl and vid_lvbl are the stage-PDLY taps.
//   - vid_r/g/b equal the delayed colour when both delayed blanks are 1, otherwise 0 (same cycle).
//   - vid_de is registered together with the colour.
//  Horizontal sync:
//   - HS enters a 16-deep shift register on pxl_cen.
//   - vid_hs = tap (PDLY + hoff_a), where hoff_a is sign-extended, giving a delay of 1..16 ticks.
//   - hoffset=0 therefore keeps HS aligned exactly as at the input, relative to blanking.
//  Vertical sync:
//   - On each vid_hs rising edge (registered edge detect on pxl_cen), VS (sampled at that tick) is shifted into a 16-line register.
//   - vid_vs = line tap (VBASE + voff_a), 0..15 lines.
//   - vid_vs changes only on the pxl_cen tick after a vid_hs rising edge.
//  Offset update:
//   - hoffset/voffset are copied into hoff_a/voff_a only on the pxl_cen tick where the delayed LVBL falls, i.e. vid_lvbl goes 1->0.
//   - Mid-frame changes have no effect until the next vertical blank; no tearing.
//  Boundary conditions:
//   - Taps are computed in 5-bit unsigned arithmetic and never wrap: -8 gives the minimum delay, +7 the maximum.
//   - If pxl_cen stays low, every output holds.
//   - If an offset update and a vid_hs edge fall on the same tick, the new offsets apply from the next tick.
//   - A reset mid-frame clears the line history, so vid_vs stays 0 for at least VBASE+voff lines.
// TESTING
//  1. Assert rst mid-line with RGB=F,F,F and blanks=1 -> all outputs 0 at once; after release, vid_r=F appears after 9 pxl_cen ticks.
//  2. hoffset=0; drive an HS pulse starting at tick T -> vid_hs rises at T+9; hoffset=-8 -> T+1; hoffset=+7 -> T+16.
//  3. Write hoffset=+3 mid-frame -> vid_hs timing unchanged until the vid_lvbl fall, then the delay is 12 ticks.
//  4. voffset=0; VS high for 8 lines -> vid_vs rises on the 8th vid_hs edge after the first line with VS=1 and stays high 8 lines; voffset=-8 -> 0 lines.
//  5. RGB=A,5,3 with LHBL_dly=0 -> vid_r/g/b=0 and vid_de=0; with LHBL_dly=LVBL_dly=1 -> A,5,3 and vid_de=1, 9 ticks later.
//  6. Hold pxl_cen=0 for 100 clk -> no output changes; resume -> sequence continues without skipping a stage.

Source files
------------

// File: rtl/jtkicker_vout.sv
// Video output stage: fixed-latency pixel pipeline with blanking, plus HS/VS
// re-timing by user offsets that only take effect at the start of vertical blank.
module jtkicker_vout #(
  parameter int PDLY  = 9,
  parameter int VBASE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic [3:0] hoffset,
  input  logic [3:0] voffset,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  input  logic       LHBL_dly,
  input  logic       LVBL_dly,
  input  logic       HS,
  input  logic       VS,
  output logic [3:0] vid_r,
  output logic [3:0] vid_g,
  output logic [3:0] vid_b,
  output logic       vid_hs,
  output logic       vid_vs,
  output logic       vid_lhbl,
  output logic       vid_lvbl,
  output logic       vid_de
);

  logic [13:0] pipe [0:PDLY-2];
  logic [13:0] last;
  logic        last_de;
  logic        lvbl_fall;
  logic [3:0]  hoff_a;
  logic [3:0]  voff_a;
  logic [15:0] hs_sr;
  logic [3:0]  hs_idx;
  logic        hs_last;
  logic        hs_rise;
  logic [14:0] vs_sr;
  logic [15:0] vs_next;
  logic [3:0]  vs_idx;

  assign last    = pipe[PDLY-2];
  assign last_de = last[1] & last[0];

  // The output registers form the final pipeline stage, so colour, blanks
  // and data-enable all emerge together after exactly PDLY ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PDLY-1; i++) pipe[i] <= '0;
      vid_r    <= '0;
      vid_g    <= '0;
      vid_b    <= '0;
      vid_lhbl <= 1'b0;
      vid_lvbl <= 1'b0;
      vid_de   <= 1'b0;
    end else if (pxl_cen) begin
      pipe[0] <= {red, green, blue, LHBL_dly, LVBL_dly};
      for (int i = 1; i < PDLY-1; i++) pipe[i] <= pipe[i-1];
      vid_lhbl <= last[1];
      vid_lvbl <= last[0];
      vid_de   <= last_de;
      vid_r    <= last_de ? last[13:10] : 4'd0;
      vid_g    <= last_de ? last[9:6]   : 4'd0;
      vid_b    <= last_de ? last[5:2]   : 4'd0;
    end
  end

  assign lvbl_fall = vid_lvbl & ~last[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hoff_a <= '0;
      voff_a <= '0;
    end else if (pxl_cen && lvbl_fall) begin
      hoff_a <= hoffset;
      voff_a <= voffset;
    end
  end

  // Tap 1 of the HS line sits in bit 0, hence the -1 on the index.
  assign hs_idx  = 4'(5'(PDLY) + {hoff_a[3], hoff_a} - 5'd1);
  assign vs_idx  = 4'(5'(VBASE) + {voff_a[3], voff_a});
  assign vid_hs  = hs_sr[hs_idx];
  assign hs_rise = vid_hs & ~hs_last;
  assign vs_next = {vs_sr, VS};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sr   <= '0;
      hs_last <= 1'b0;
      vs_sr   <= '0;
      vid_vs  <= 1'b0;
    end else if (pxl_cen) begin
      hs_sr   <= {hs_sr[14:0], HS};
      hs_last <= vid_hs;
      if (hs_rise) begin
        vs_sr  <= vs_next[14:0];
        vid_vs <= vs_next[vs_idx];
      end
    end
  end

endmodule
